// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bundle: redirect input, instruction-memory request/ack port and decode-side valid/ready queue output.
interface fetch_queue_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;

  modport master (
    input  redirect_valid,
    input  redirect_pc,
    input  imem_ack,
    input  imem_rdata,
    input  out_ready,
    output imem_req,
    output imem_addr,
    output out_valid,
    output out_instr,
    output out_pc4
  );

  modport slave (
    output redirect_valid,
    output redirect_pc,
    output imem_ack,
    output imem_rdata,
    output out_ready,
    input  imem_req,
    input  imem_addr,
    input  out_valid,
    input  out_instr,
    input  out_pc4
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// MIPS fetch front end: owns the PC, issues word fetches and queues {instr, pc+4} for decode.
// A redirect flushes the queue; a fetch still outstanding at that moment is drained in DROP and discarded.
module fetch_queue_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  fetch_queue_stage_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      r_drop_addr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [31:0]      r_instr_mem [QUEUE_DEPTH];
  logic [31:0]      r_pc4_mem   [QUEUE_DEPTH];

  logic             w_req;
  logic [31:0]      w_addr;
  logic             w_ack;
  logic             w_push;
  logic             w_pop;
  logic             w_drop_enter;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_redirect_target;
  logic [1:0]       w_unused_pc_lsb;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb   = bus.redirect_pc[1:0];

  // Request generation and next-state selection
  always_comb begin
    w_req        = 1'b0;
    w_addr       = r_pc;
    w_drop_enter = 1'b0;
    w_state_nxt  = r_state;
    case (r_state)
      ST_FETCH: begin
        w_req  = (r_count < CNT_FULL);
        w_addr = r_pc;
        // An unanswered request must keep its address, so park it in DROP.
        if (bus.redirect_valid && w_req && !bus.imem_ack) begin
          w_drop_enter = 1'b1;
          w_state_nxt  = ST_DROP;
        end else begin
          w_drop_enter = 1'b0;
          w_state_nxt  = ST_FETCH;
        end
      end
      ST_DROP: begin
        w_req  = 1'b1;
        w_addr = r_drop_addr;
        if (bus.imem_ack) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  assign w_ack  = w_req && bus.imem_ack;
  assign w_push = (r_state == ST_FETCH) && w_ack && !bus.redirect_valid;
  assign w_pop  = (r_count != {CNT_W{1'b0}}) && bus.out_ready && !bus.redirect_valid;

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = w_addr;
  assign bus.out_valid = (r_count != {CNT_W{1'b0}});
  assign bus.out_instr = r_instr_mem[r_head];
  assign bus.out_pc4   = r_pc4_mem[r_head];

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and latched address of the request being dropped
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_drop_addr <= 32'h0000_0000;
    end else begin
      if (bus.redirect_valid) begin
        r_pc <= w_redirect_target;
      end else if (w_push) begin
        r_pc <= w_pc_plus4;
      end else begin
        r_pc <= r_pc;
      end
      if (w_drop_enter) begin
        r_drop_addr <= r_pc;
      end else begin
        r_drop_addr <= r_drop_addr;
      end
    end
  end

  // Queue occupancy and pointers; a redirect voids any same-cycle push or pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= {CNT_W{1'b0}};
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
    end else if (bus.redirect_valid) begin
      r_count <= {CNT_W{1'b0}};
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end else begin
        r_tail <= r_tail;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end else begin
        r_head <= r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: instruction word and its PC+4
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_instr_mem[i] <= 32'h0000_0000;
        r_pc4_mem[i]   <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_instr_mem[r_tail] <= bus.imem_rdata;
      r_pc4_mem[r_tail]   <= w_pc_plus4;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_instr_mem[i] <= r_instr_mem[i];
        r_pc4_mem[i]   <= r_pc4_mem[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: queue-level reference model checked every cycle, plus directed literal checks.
module tb_fetch_queue_stage;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;
  int   wait_cnt;

  always #5 clock = ~clock;

  fetch_queue_stage_if bus ();
  fetch_queue_stage_if bus2 ();

  fetch_queue_stage #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .bus(bus.master));

  fetch_queue_stage #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(DEPTH)) dut_wrap (
    .clock(clock), .reset(reset), .bus(bus2.master));

  // Memory: word at A is A ^ DEAD_0000, ack after lat wait cycles (lat=0 means same cycle)
  always_comb begin
    bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
    bus.imem_rdata = bus.imem_ack ? (bus.imem_addr ^ 32'hDEAD_0000) : 32'h0000_0000;
    bus2.imem_ack   = bus2.imem_req;
    bus2.imem_rdata = bus2.imem_addr ^ 32'hDEAD_0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, fetch PC and pending-drop address
  logic [31:0] m_pc;
  bit          m_drop;
  logic [31:0] m_drop_addr;
  bit          m_fresh;
  logic [63:0] m_q[$];

  always @(negedge clock) begin
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          acc;
    bit          pop;
    if (reset) begin
      m_pc = 32'h0000_0000; m_drop = 0; m_drop_addr = 32'h0; m_fresh = 1; m_q.delete();
    end
    exp_req  = m_drop ? 1'b1 : (m_q.size() < DEPTH);
    exp_addr = m_drop ? m_drop_addr : m_pc;
    check_b("model_req", bus.imem_req, exp_req);
    if (exp_req) check("model_addr", bus.imem_addr, exp_addr);
    check_b("model_valid", bus.out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("model_instr", bus.out_instr, m_q[0][63:32]);
      check("model_pc4", bus.out_pc4, m_q[0][31:0]);
    end else if (m_fresh) begin
      check("model_instr_rst", bus.out_instr, 32'h0000_0000);
      check("model_pc4_rst", bus.out_pc4, 32'h0000_0000);
    end
    if (!reset) begin
      acc = exp_req && bus.imem_ack;
      pop = (m_q.size() != 0) && bus.out_ready;
      if (bus.redirect_valid) begin
        m_q.delete();
        if (!m_drop && exp_req && !acc) begin
          m_drop = 1; m_drop_addr = m_pc;
        end else if (m_drop && acc) begin
          m_drop = 0;
        end
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (m_drop) begin
        if (acc) m_drop = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (acc) begin
          m_q.push_back({m_pc ^ 32'hDEAD_0000, m_pc + 32'd4});
          m_pc = m_pc + 32'd4;
          m_fresh = 0;
        end
      end
    end
  end

  task automatic wait_neg();
    @(negedge clock);
    #2;
  endtask

  task automatic do_reset(input logic ready, input int latency);
    @(posedge clock); #1;
    reset = 1'b1; lat = latency; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; bus.out_ready = ready;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      wait_neg();
      if (bus.imem_req && bus.imem_addr == a) begin
        found = 1;
        break;
      end
    end
    check_b(name, found, 1'b1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      wait_neg();
      if (bus.out_valid) begin
        found = 1;
        break;
      end
    end
    check_b(name, found, 1'b1);
  endtask

  task automatic redirect_once(input logic [31:0] target);
    @(posedge clock); #1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = target;
    @(posedge clock); #1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.out_ready = 1'b0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.out_ready = 1'b1;

    // Zero-wait streaming from reset, plus PC wrap on the second instance
    do_reset(1'b1, 0);
    wait_neg();
    check("t1_addr0", bus.imem_addr, 32'h0);
    check_b("t1_valid0", bus.out_valid, 1'b0);
    check("t1_wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
    wait_neg();
    check("t1_instr0", bus.out_instr, 32'hDEAD_0000);
    check("t1_pc4_0", bus.out_pc4, 32'h4);
    check("t1_addr1", bus.imem_addr, 32'h4);
    check("t1_wrap_pc4_0", bus2.out_pc4, 32'hFFFF_FFFC);
    check("t1_wrap_instr0", bus2.out_instr, 32'h2152_FFF8);
    wait_neg();
    check("t1_instr1", bus.out_instr, 32'hDEAD_0004);
    check("t1_pc4_1", bus.out_pc4, 32'h8);
    check("t1_wrap_pc4_1", bus2.out_pc4, 32'h0000_0000);
    check("t1_wrap_addr2", bus2.imem_addr, 32'h0000_0000);
    wait_neg();
    check("t1_instr2", bus.out_instr, 32'hDEAD_0008);
    check("t1_wrap_pc4_2", bus2.out_pc4, 32'h0000_0004);
    repeat (3) wait_neg();

    // Back-pressure: two pushes then stall, resume at 8 one cycle after ready
    do_reset(1'b0, 0);
    wait_neg();
    wait_neg();
    check("t2_addr1", bus.imem_addr, 32'h4);
    wait_neg();
    check_b("t2_req_full", bus.imem_req, 1'b0);
    repeat (3) wait_neg();
    check_b("t2_req_held", bus.imem_req, 1'b0);
    check("t2_instr_held", bus.out_instr, 32'hDEAD_0000);
    check("t2_pc4_held", bus.out_pc4, 32'h4);
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    wait_neg();
    check_b("t2_req_same_cycle", bus.imem_req, 1'b0);
    wait_neg();
    check_b("t2_req_resume", bus.imem_req, 1'b1);
    check("t2_addr_resume", bus.imem_addr, 32'h8);
    check("t2_instr_next", bus.out_instr, 32'hDEAD_0004);
    wait_neg();
    check("t2_instr_after", bus.out_instr, 32'hDEAD_0008);

    // Slow memory: redirect while request to 4 is outstanding
    do_reset(1'b1, 3);
    wait_req_addr(32'h4, 20, "t3_reach_addr4");
    redirect_once(32'h0000_0103);
    wait_neg();
    check_b("t3_req_drop", bus.imem_req, 1'b1);
    check("t3_addr_drop", bus.imem_addr, 32'h4);
    wait_req_addr(32'h100, 20, "t3_reach_target");
    wait_valid(20, "t3_valid_target");
    check("t3_instr_target", bus.out_instr, 32'hDEAD_0100);
    check("t3_pc4_target", bus.out_pc4, 32'h104);

    // Redirect coincident with zero-wait ack and pop, one entry held
    do_reset(1'b1, 0);
    repeat (4) wait_neg();
    redirect_once(32'h0000_0200);
    wait_neg();
    check_b("t4_valid_flush", bus.out_valid, 1'b0);
    check("t4_addr_target", bus.imem_addr, 32'h200);
    wait_neg();
    check_b("t4_valid_new", bus.out_valid, 1'b1);
    check("t4_instr_new", bus.out_instr, 32'hDEAD_0200);
    check("t4_pc4_new", bus.out_pc4, 32'h204);

    // Asynchronous reset with the queue full
    do_reset(1'b0, 0);
    repeat (3) wait_neg();
    check_b("t5_full_req", bus.imem_req, 1'b0);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check_b("t5_rst_valid", bus.out_valid, 1'b0);
    check("t5_rst_instr", bus.out_instr, 32'h0);
    check("t5_rst_pc4", bus.out_pc4, 32'h0);
    check("t5_rst_addr", bus.imem_addr, 32'h0);

    // Asynchronous reset while a drop is pending
    do_reset(1'b1, 3);
    wait_req_addr(32'h4, 20, "t6_reach_addr4");
    redirect_once(32'h0000_0040);
    wait_neg();
    check("t6_addr_drop", bus.imem_addr, 32'h4);
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check_b("t6_rst_req", bus.imem_req, 1'b1);
    check("t6_rst_addr", bus.imem_addr, 32'h0);
    check_b("t6_rst_valid", bus.out_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_neg();
    check("t6_first_addr", bus.imem_addr, 32'h0);
    wait_valid(20, "t6_valid_first");
    check("t6_first_instr", bus.out_instr, 32'hDEAD_0000);
    check("t6_first_pc4", bus.out_pc4, 32'h4);
    repeat (2) wait_neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch front end for the pipelined MIPS core; sits directly upstream of decode.
- Owns the PC and issues word fetches to instruction memory over a request/acknowledge port.
- Buffers returned instructions, each with its PC+4, in a small FIFO drained by decode through a valid/ready handshake.
- Accepts branch/jump redirects from downstream: flushes the FIFO and discards any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
QUEUE_DEPTH, 2, FIFO entries; power of two, at least 2

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0)
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  fetch address, word aligned, stable while imem_req is high
imem_ack  input  1  memory returns data this cycle; may be asserted in the same cycle as imem_req (zero wait)
imem_rdata  input  32  instruction word, valid when imem_ack is high
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_instr  output  32  head instruction
out_pc4  output  32  head PC+4, used by decode for branch/jump targets

Behaviour:
- Reset, asynchronous: pc=RESET_PC, FIFO empty (count=0, pointers 0), state=FETCH, out_valid=0, out_instr=0, out_pc4=0. imem_req follows the rules below with count=0. Instruction memory shares the same reset, so no stale ack survives reset.
- FIFO: count range 0..QUEUE_DEPTH. Pointers wrap modulo QUEUE_DEPTH. out_valid = (count!=0). out_instr and out_pc4 are driven from head storage, with no combinational path from imem_rdata.
- Pop: out_valid && out_ready. Push: an accepted fetch response. Push and pop in the same cycle leave count unchanged.
- States:
  - FETCH: imem_req = (count < QUEUE_DEPTH); imem_addr = pc.
    - On imem_req && imem_ack with no redirect: push {imem_rdata, pc+4}; pc <= pc+4; stay in FETCH.
    - Full FIFO: imem_req=0. A pop in that cycle does not enable a request in the same cycle; the request rises the next cycle.
  - DROP: imem_req=1; imem_addr = the address latched when the redirect arrived (drop_addr). pc already holds the redirect target.
    - On imem_ack: discard data, no push; next state FETCH.
- Redirect, highest priority, any state:
  - FIFO cleared (count=0) in the same cycle; a simultaneous pop or push is void.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - FETCH with imem_req high and no imem_ack this cycle: drop_addr <= pc; go to DROP.
  - FETCH with imem_req high and imem_ack this cycle: data discarded; stay in FETCH.
  - FETCH with imem_req low: stay in FETCH.
  - DROP without ack: stay in DROP; drop_addr unchanged.
  - DROP with ack: go to FETCH.
- Request stability: while imem_req is high and imem_ack is low, imem_addr must not change, including across a redirect (handled by DROP).
- Arithmetic: pc+4 is 32-bit and wraps; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Latency:
  - Zero-wait memory gives one fetch per cycle while the FIFO is not full.
  - First out_valid appears one cycle after the first ack.
  - Redirect to first new-target out_valid: 2 cycles with zero-wait memory.

Test Plan:
- Zero-wait memory where word at address A = A ^ 32'hDEAD_0000, out_ready=1 after reset release -> imem_addr 0,4,8,... on consecutive cycles; out_instr sequence 32'hDEAD_0000, 32'hDEAD_0004,...; out_pc4 4,8,12; no gaps.
- out_ready=0 with zero-wait memory -> exactly 2 pushes, then imem_req=0 and out_instr=32'hDEAD_0000 held; raise out_ready -> fetching resumes at addr 8 one cycle later, order preserved.
- Memory with 3-cycle ack latency; redirect_pc=32'h0000_0103 one cycle after a request to addr 4 -> imem_addr stays 4 until ack, that data is never output; next request addr 32'h100; first out_instr=word at 32'h100, out_pc4=32'h104.
- Redirect in the same cycle as a zero-wait ack and a pop with FIFO holding 1 entry -> next cycle count=0, out_valid=0, imem_addr=target; the acked word is never output.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory -> out_pc4 values 32'hFFFF_FFFC, 32'h0000_0000; imem_addr wraps to 0.
- Assert reset mid-stream with FIFO full and DROP pending -> immediately out_valid=0, pc=RESET_PC, state FETCH; after release, the first fetch is at RESET_PC.
